// File: rtl/spook_lwc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spook_lwc_pkg
// Description : Shared constants and types for the Spook LWC output bus:
//               dtype codes, status codes, header field positions, record kinds.
// Revision    : 1.0 - initial release
// ============================================================================
package spook_lwc_pkg;

  localparam logic [3:0] c_dtype_ad    = 4'h1;
  localparam logic [3:0] c_dtype_pt    = 4'h4;
  localparam logic [3:0] c_dtype_ct    = 4'h5;
  localparam logic [3:0] c_dtype_tag   = 4'h8;
  localparam logic [3:0] c_dtype_key   = 4'hC;
  localparam logic [3:0] c_dtype_nonce = 4'hD;

  localparam logic [3:0] c_status_ok   = 4'hE;
  localparam logic [3:0] c_status_fail = 4'hF;

  localparam int c_hdr_dtype_msb = 31;
  localparam int c_hdr_eoi       = 26;
  localparam int c_hdr_eot       = 25;
  localparam int c_hdr_last      = 24;
  localparam int c_hdr_len_msb   = 15;

  typedef enum logic [1:0] {
    c_rec_header = 2'd0,
    c_rec_data   = 2'd1,
    c_rec_status = 2'd2
  } rec_kind_t;

  function automatic logic is_status_code(input logic [3:0] nib);
    return (nib == c_status_ok) || (nib == c_status_fail);
  endfunction

  // Byte 0 sits in the MSB lane, so a partial word fills lanes from the top.
  function automatic logic [3:0] byte_mask(input logic [15:0] rem);
    logic [3:0] m;
    case (rem)
      16'd0:   m = 4'b0000;
      16'd1:   m = 4'b1000;
      16'd2:   m = 4'b1100;
      16'd3:   m = 4'b1110;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lwc_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : lwc_out_reg
// Description : Single valid/ready register slice carrying one parsed record.
// Revision    : 1.0 - initial release
// ============================================================================
module lwc_out_reg #(
  parameter int BUS_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  up_ready,
  input  logic [1:0]            in_kind,
  input  logic [BUS_SIZE-1:0]   in_data,
  input  logic [BUS_SIZE/8-1:0] in_validity,
  input  logic [3:0]            in_dtype,
  input  logic                  in_last_of_seg,
  input  logic                  in_status_ok,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [1:0]            rec_kind,
  output logic [BUS_SIZE-1:0]   rec_data,
  output logic [BUS_SIZE/8-1:0] rec_validity,
  output logic [3:0]            rec_dtype,
  output logic                  rec_last_of_seg,
  output logic                  status_ok
);

  // Refill in the same cycle the consumer drains, giving full throughput.
  assign up_ready = ~rec_valid | rec_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_valid       <= 1'b0;
      rec_kind        <= 2'd0;
      rec_data        <= '0;
      rec_validity    <= '0;
      rec_dtype       <= 4'h0;
      rec_last_of_seg <= 1'b0;
      status_ok       <= 1'b0;
    end else if (load) begin
      rec_valid       <= 1'b1;
      rec_kind        <= in_kind;
      rec_data        <= in_data;
      rec_validity    <= in_validity;
      rec_dtype       <= in_dtype;
      rec_last_of_seg <= in_last_of_seg;
      status_ok       <= in_status_ok;
    end else if (rec_ready) begin
      rec_valid       <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spook_resp_parser.sv
`default_nettype none
// ============================================================================
// Module      : spook_resp_parser
// Description : Splits the Spook core output word stream into header, data and
//               status records and flags framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module spook_resp_parser
  import spook_lwc_pkg::*;
#(
  parameter int BUS_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_SIZE-1:0]   bus_in,
  input  logic                  bus_in_valid,
  output logic                  bus_in_ready,
  input  logic                  bus_in_last,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [1:0]            rec_kind,
  output logic [BUS_SIZE-1:0]   rec_data,
  output logic [BUS_SIZE/8-1:0] rec_validity,
  output logic [3:0]            rec_dtype,
  output logic                  rec_last_of_seg,
  output logic                  status_ok,
  output logic                  proto_err
);

  localparam int BUSdiv8 = BUS_SIZE / 8;

  localparam logic [0:0] S_HDR  = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  logic [0:0]         r_state;
  logic [15:0]        r_rem;
  logic [3:0]         r_dtype;
  logic               r_last_seen;
  logic               r_seg_open;
  logic               r_proto_err;

  logic               w_accept;
  logic [3:0]         w_nibble;
  logic [15:0]        w_hdr_len;
  logic               w_is_status;
  logic [15:0]        w_step;
  logic [15:0]        w_rem_next;
  rec_kind_t          w_kind;
  logic [BUSdiv8-1:0] w_validity;
  logic [3:0]         w_dtype;
  logic               w_last_of_seg;
  logic               w_status_ok;
  logic               w_err_now;

  assign w_accept    = bus_in_valid & bus_in_ready;
  assign w_nibble    = bus_in[c_hdr_dtype_msb -: 4];
  assign w_hdr_len   = bus_in[c_hdr_len_msb -: 16];
  assign w_is_status = (r_state == S_HDR) && is_status_code(w_nibble);
  assign w_step      = (r_rem >= 16'd4) ? 16'd4 : r_rem;
  assign w_rem_next  = r_rem - w_step;
  assign proto_err   = r_proto_err;

  always_comb begin
    w_kind        = c_rec_header;
    w_validity    = '1;
    w_dtype       = w_nibble;
    w_last_of_seg = 1'b0;
    w_status_ok   = 1'b0;
    w_err_now     = bus_in_last;
    if (w_is_status) begin
      w_kind      = c_rec_status;
      w_dtype     = 4'h0;
      w_status_ok = (w_nibble == c_status_ok);
      // A status closing a segment must follow a header marked last.
      w_err_now   = ~bus_in_last | (r_seg_open & ~r_last_seen);
    end else if (r_state == S_DATA) begin
      w_kind        = c_rec_data;
      w_validity    = byte_mask(r_rem);
      w_dtype       = r_dtype;
      w_last_of_seg = (w_rem_next == 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HDR;
      r_rem       <= 16'd0;
      r_dtype     <= 4'h0;
      r_last_seen <= 1'b0;
      r_seg_open  <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (w_accept) begin
      r_proto_err <= r_proto_err | w_err_now;
      case (r_state)
        S_HDR: begin
          if (w_is_status) begin
            r_last_seen <= 1'b0;
            r_seg_open  <= 1'b0;
          end else begin
            r_dtype     <= w_nibble;
            r_last_seen <= bus_in[c_hdr_last];
            r_seg_open  <= 1'b1;
            r_rem       <= w_hdr_len;
            r_state     <= (w_hdr_len == 16'd0) ? S_HDR : S_DATA;
          end
        end
        S_DATA: begin
          r_rem <= w_rem_next;
          if (w_rem_next == 16'd0) begin
            r_state <= S_HDR;
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

  lwc_out_reg #(
    .BUS_SIZE (BUS_SIZE)
  ) u_out_reg (
    .clk             (clk),
    .rst             (rst),
    .load            (w_accept),
    .up_ready        (bus_in_ready),
    .in_kind         (w_kind),
    .in_data         (bus_in),
    .in_validity     (w_validity),
    .in_dtype        (w_dtype),
    .in_last_of_seg  (w_last_of_seg),
    .in_status_ok    (w_status_ok),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_kind        (rec_kind),
    .rec_data        (rec_data),
    .rec_validity    (rec_validity),
    .rec_dtype       (rec_dtype),
    .rec_last_of_seg (rec_last_of_seg),
    .status_ok       (status_ok)
  );

endmodule
`default_nettype wire

// File: tb/tb_spook_resp_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_spook_resp_parser
// Description : Randomized self-checking bench for spook_resp_parser against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spook_resp_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_in;
  logic        bus_in_valid;
  logic        bus_in_ready;
  logic        bus_in_last;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_kind;
  logic [31:0] rec_data;
  logic [3:0]  rec_validity;
  logic [3:0]  rec_dtype;
  logic        rec_last_of_seg;
  logic        status_ok;
  logic        proto_err;

  always #5 clk = ~clk;

  spook_resp_parser #(.BUS_SIZE(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus_in          (bus_in),
    .bus_in_valid    (bus_in_valid),
    .bus_in_ready    (bus_in_ready),
    .bus_in_last     (bus_in_last),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_kind        (rec_kind),
    .rec_data        (rec_data),
    .rec_validity    (rec_validity),
    .rec_dtype       (rec_dtype),
    .rec_last_of_seg (rec_last_of_seg),
    .status_ok       (status_ok),
    .proto_err       (proto_err)
  );

  typedef struct {
    logic [31:0] w;
    logic        last;
  } word_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [3:0]  validity;
    logic [3:0]  dtype;
    logic        los;
    logic        ok;
    logic        err;
  } exp_t;

  word_t w_q[$];
  exp_t  e_q[$];
  int    total = 0;
  int    bad   = 0;

  // Frame-level model state
  logic m_err       = 1'b0;
  logic m_seg_open  = 1'b0;
  logic m_last_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic put(input logic [31:0] w, input logic last, input logic [1:0] kind,
                     input logic [3:0] vmask, input logic [3:0] dt, input logic los,
                     input logic ok, input logic word_err);
    word_t wd;
    exp_t  ex;
    m_err       = m_err | word_err;
    wd.w        = w;
    wd.last     = last;
    ex.kind     = kind;
    ex.data     = w;
    ex.validity = vmask;
    ex.dtype    = dt;
    ex.los      = los;
    ex.ok       = ok;
    ex.err      = m_err;
    w_q.push_back(wd);
    e_q.push_back(ex);
  endtask

  // bad_idx: -1 clean, 0 flags the header word, k flags the k-th data word
  task automatic add_segment(input logic [31:0] h, input int bad_idx);
    int          rem;
    int          n;
    logic [3:0]  mk;
    logic [3:0]  dt;
    dt = h[31:28];
    put(h, bad_idx == 0, 2'd0, 4'hF, dt, 1'b0, 1'b0, bad_idx == 0);
    m_seg_open  = 1'b1;
    m_last_seen = h[24];
    rem = int'(h[15:0]);
    for (int k = 1; rem > 0; k++) begin
      n   = (rem > 4) ? 4 : rem;
      mk  = {n >= 1, n >= 2, n >= 3, n >= 4};
      rem = rem - n;
      put($urandom, bad_idx == k, 2'd1, mk, dt, rem == 0, 1'b0, bad_idx == k);
    end
  endtask

  task automatic add_status(input logic [31:0] w, input logic last);
    logic e;
    e = !last || (m_seg_open && !m_last_seen);
    put(w, last, 2'd2, 4'hF, 4'h0, 1'b0, w[31:28] == 4'hE, e);
    m_seg_open  = 1'b0;
    m_last_seen = 1'b0;
  endtask

  task automatic add_frame(input bit inject);
    int          nseg;
    int          len;
    logic        hlast;
    logic [3:0]  dt;
    logic [31:0] h;
    nseg = $urandom_range(0, 3);
    for (int s = 0; s < nseg; s++) begin
      dt    = 4'($urandom_range(0, 13));
      len   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 24);
      hlast = (s == nseg - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      h     = {dt, 1'b0, 2'($urandom), hlast, 8'($urandom), 16'(len)};
      add_segment(h, (inject && s == 0) ? 0 : -1);
    end
    add_status({($urandom_range(0, 1) == 1) ? 4'hE : 4'hF, 28'($urandom)}, !(inject && nseg == 0));
  endtask

  task automatic check_rec();
    exp_t e;
    if (e_q.size() == 0) begin
      chk("spurious_rec", 32'(rec_valid), 32'd0);
    end else begin
      e = e_q.pop_front();
      chk("rec_kind", 32'(rec_kind), 32'(e.kind));
      chk("rec_data", rec_data, e.data);
      chk("rec_validity", 32'(rec_validity), 32'(e.validity));
      if (e.kind != 2'd2) chk("rec_dtype", 32'(rec_dtype), 32'(e.dtype));
      if (e.kind == 2'd1) chk("rec_last_of_seg", 32'(rec_last_of_seg), 32'(e.los));
      if (e.kind == 2'd2) chk("status_ok", 32'(status_ok), 32'(e.ok));
      chk("proto_err", 32'(proto_err), 32'(e.err));
    end
  endtask

  task automatic run(input int gap_pct, input int stall_pct, input bit hold_test);
    int cyc       = 0;
    bit sent      = 0;
    bit held      = 0;
    int hold_left = 0;
    while ((w_q.size() > 0 || e_q.size() > 0 || bus_in_valid) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (sent) bus_in_valid = 1'b0;
      sent = 0;
      if (!bus_in_valid && w_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        bus_in_valid = 1'b1;
        bus_in       = w_q[0].w;
        bus_in_last  = w_q[0].last;
      end
      if (hold_test && !held && rec_valid && rec_kind == 2'd1) begin
        held      = 1;
        hold_left = 5;
      end
      if (hold_left > 0) rec_ready = 1'b0;
      else               rec_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (hold_left > 0) begin
        chk("hold_bus_in_ready", 32'(bus_in_ready), 32'd0);
        hold_left--;
      end
      if (rec_valid && rec_ready) check_rec();
      if (bus_in_valid && bus_in_ready) begin
        void'(w_q.pop_front());
        sent = 1;
      end
    end
    if (w_q.size() > 0 || e_q.size() > 0) begin
      chk("timeout_pending", 32'(w_q.size() + e_q.size()), 32'd0);
      w_q.delete();
      e_q.delete();
    end
    bus_in_valid = 1'b0;
    bus_in_last  = 1'b0;
    rec_ready    = 1'b1;
  endtask

  task automatic do_reset(input bit full);
    rst          = 1'b0;
    bus_in_valid = 1'b0;
    bus_in_last  = 1'b0;
    rec_ready    = 1'b0;
    #1;
    chk("rst_rec_valid", 32'(rec_valid), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    if (full) begin
      chk("rst_rec_kind", 32'(rec_kind), 32'd0);
      chk("rst_rec_data", rec_data, 32'd0);
      chk("rst_rec_validity", 32'(rec_validity), 32'd0);
      chk("rst_rec_dtype", 32'(rec_dtype), 32'd0);
      chk("rst_rec_last_of_seg", 32'(rec_last_of_seg), 32'd0);
      chk("rst_status_ok", 32'(status_ok), 32'd0);
      chk("rst_bus_in_ready", 32'(bus_in_ready), 32'd1);
    end
    repeat (2) @(negedge clk);
    chk("rst_hold_rec_valid", 32'(rec_valid), 32'd0);
    rst = 1'b1;
    w_q.delete();
    e_q.delete();
    m_err       = 1'b0;
    m_seg_open  = 1'b0;
    m_last_seen = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus_in       = 32'h0;
    bus_in_valid = 1'b0;
    bus_in_last  = 1'b0;
    rec_ready    = 1'b0;
    #2;
    do_reset(1);

    // Lone success status
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 0);

    // Segment of 5 bytes then status
    add_segment(32'h5300_0005, -1);
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 0);

    // Zero-length segment followed by a full-word segment
    add_segment(32'h1200_0000, -1);
    add_segment(32'h5300_0004, -1);
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 0);

    // Consumer stall during a 12-byte burst
    add_segment(32'h4300_000C, -1);
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 1);

    // Boundary lengths 1..9 in one frame
    for (int l = 1; l <= 9; l++) add_segment({4'h1, 4'h0, 8'h00, 16'(l)}, -1);
    add_segment(32'h8100_0010, -1);
    add_status(32'hF000_0000, 1'b1);
    run(10, 20, 0);

    // Clean random traffic
    for (int g = 0; g < 6; g++) begin
      for (int f = 0; f < 6; f++) add_frame(0);
      run(25, 35, 0);
    end
    chk("clean_proto_err", 32'(proto_err), 32'd0);

    // Stray last on a data word: error is sticky
    add_segment(32'h5300_0008, 1);
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 0);
    repeat (4) @(negedge clk);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
    for (int f = 0; f < 4; f++) add_frame(f[0]);
    run(20, 20, 0);

    // Status without last flag
    do_reset(0);
    add_status(32'hE000_0000, 1'b0);
    run(0, 0, 0);

    // Segment whose header is not marked last, closed by a status
    do_reset(0);
    add_segment(32'h4000_0003, -1);
    add_status(32'hE000_0000, 1'b1);
    run(0, 0, 0);

    // Random frames with injected framing errors
    do_reset(0);
    for (int f = 0; f < 5; f++) add_frame(1);
    run(15, 25, 0);

    // Reset mid-segment, then a failure status parses cleanly
    do_reset(0);
    add_segment(32'h5300_000C, -1);
    while (w_q.size() > 2) begin
      void'(w_q.pop_back());
      void'(e_q.pop_back());
    end
    run(0, 0, 0);
    do_reset(0);
    add_status(32'hF000_0000, 1'b1);
    run(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
